// File: rtl/control_cmd_readrow_ctrl.sv
// Load-row command handler: a row-address byte followed by the row's pixel bytes,
// each pixel byte turned into a single-cycle RAM write with row/column/byte addresses.
module control_cmd_readrow_ctrl #(
  parameter int PIXEL_WIDTH     = 64,
  parameter int PIXEL_HEIGHT    = 32,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int ROW_BITS        = $clog2(PIXEL_HEIGHT),
  parameter int COL_BITS        = $clog2(PIXEL_WIDTH),
  parameter int PIX_BITS        = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [7:0]          data_in,
  output logic [ROW_BITS-1:0] row,
  output logic [COL_BITS-1:0] column,
  output logic [PIX_BITS-1:0] pixel,
  output logic [7:0]          data_out,
  output logic                ram_write_enable,
  output logic                ram_access_start,
  output logic                done
);

  localparam logic [COL_BITS-1:0] COL_LAST  = COL_BITS'(PIXEL_WIDTH - 1);
  localparam logic [PIX_BITS-1:0] BYTE_LAST = PIX_BITS'(BYTES_PER_PIXEL - 1);

  typedef enum logic [1:0] {
    ST_ROW  = 2'd0,
    ST_DATA = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state;
  logic [COL_BITS-1:0] col_cnt;
  logic [PIX_BITS-1:0] byte_cnt;
  logic                first;

  // Row FSM with registered write/address outputs; counters walk MSB-first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_ROW;
      col_cnt          <= COL_LAST;
      byte_cnt         <= BYTE_LAST;
      first            <= 1'b0;
      row              <= '0;
      column           <= '0;
      pixel            <= '0;
      data_out         <= 8'h00;
      ram_write_enable <= 1'b0;
      ram_access_start <= 1'b0;
      done             <= 1'b0;
    end else begin
      ram_write_enable <= 1'b0;
      ram_access_start <= 1'b0;
      done             <= 1'b0;
      case (state)
        ST_ROW: begin
          if (enable) begin
            row      <= data_in[ROW_BITS-1:0];
            col_cnt  <= COL_LAST;
            byte_cnt <= BYTE_LAST;
            first    <= 1'b1;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (enable) begin
            data_out         <= data_in;
            column           <= col_cnt;
            pixel            <= byte_cnt;
            ram_write_enable <= 1'b1;
            ram_access_start <= first;
            first            <= 1'b0;
            if (byte_cnt == '0) begin
              byte_cnt <= BYTE_LAST;
              if (col_cnt == '0) begin
                state <= ST_DONE;
              end else begin
                col_cnt <= col_cnt - COL_BITS'(1);
              end
            end else begin
              byte_cnt <= byte_cnt - PIX_BITS'(1);
            end
          end
        end
        ST_DONE: begin
          // A strobe landing here is deliberately dropped.
          done  <= 1'b1;
          state <= ST_ROW;
        end
        default: begin
          state <= ST_ROW;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_cmd_readrow_ctrl.sv
// Randomized scoreboard bench for control_cmd_readrow_ctrl: expected writes are
// queued by an arithmetic row model and a monitor pops them as the DUT writes.
module tb_control_cmd_readrow_ctrl;

  localparam int PW  = 64;
  localparam int PH  = 32;
  localparam int BPP = 2;
  localparam int NB  = PW * BPP;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] data_in;
  logic [4:0] row;
  logic [5:0] column;
  logic [0:0] pixel;
  logic [7:0] data_out;
  logic       ram_write_enable;
  logic       ram_access_start;
  logic       done;

  typedef struct {
    int  r;
    int  c;
    int  p;
    int  d;
    bit  start;
    bit  last;
  } wr_t;

  wr_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  writes_seen = 0;
  int  starts_seen = 0;
  int  dones_seen = 0;
  int  writes_exp = 0;
  int  starts_exp = 0;
  int  dones_exp = 0;
  bit  done_due = 1'b0;

  control_cmd_readrow_ctrl #(
    .PIXEL_WIDTH(PW), .PIXEL_HEIGHT(PH), .BYTES_PER_PIXEL(BPP)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .data_in(data_in),
    .row(row), .column(column), .pixel(pixel), .data_out(data_out),
    .ram_write_enable(ram_write_enable), .ram_access_start(ram_access_start),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare on every write; done must follow the final write by one cycle.
  always @(negedge clk) begin
    if (reset) begin
      done_due = 1'b0;
    end else begin
      if (done) dones_seen++;
      if (done_due) check("done_after_last", int'(done), 1);
      else if (done) check("spurious_done", 1, 0);
      done_due = 1'b0;
      if (ram_write_enable) begin
        writes_seen++;
        if (ram_access_start) starts_seen++;
        if (q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          wr_t e;
          e = q.pop_front();
          check("row", int'(row), e.r);
          check("column", int'(column), e.c);
          check("pixel", int'(pixel), e.p);
          check("data_out", int'(data_out), e.d);
          check("access_start", int'(ram_access_start), int'(e.start));
          done_due = e.last;
        end
      end else if (ram_access_start) begin
        check("start_without_write", 1, 0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    enable  = 1'b1;
    data_in = b;
    @(negedge clk);
    enable  = 1'b0;
    data_in = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  // Model: byte k of a row addresses column PW-1-k/BPP, byte index BPP-1-k%BPP.
  task automatic send_row(input logic [7:0] rb, input int nbytes, input bit seq,
                          input int fixed_gap, input int pause_at);
    int gap;
    gap = (fixed_gap > 0) ? fixed_gap : int'($urandom_range(1, 6));
    send_byte(rb, gap);
    check("row_latch", int'(row), int'(rb) % PH);
    for (int k = 0; k < nbytes; k++) begin
      wr_t e;
      logic [7:0] d;
      d = seq ? 8'(k) : 8'($urandom);
      e.r = int'(rb) % PH;
      e.c = PW - 1 - k / BPP;
      e.p = BPP - 1 - k % BPP;
      e.d = int'(d);
      e.start = (k == 0);
      e.last  = (k == NB - 1);
      q.push_back(e);
      writes_exp++;
      if (e.start) starts_exp++;
      if (e.last) dones_exp++;
      gap = (fixed_gap > 0) ? fixed_gap : int'($urandom_range(1, 6));
      send_byte(d, gap);
      if (k == pause_at) repeat (25 * 16) @(negedge clk);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_row"}, int'(row), 0);
    check({tag, "_column"}, int'(column), 0);
    check({tag, "_pixel"}, int'(pixel), 0);
    check({tag, "_data_out"}, int'(data_out), 0);
    check({tag, "_wen"}, int'(ram_write_enable), 0);
    check({tag, "_start"}, int'(ram_access_start), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    data_in = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;

    // Row byte only, then a full row 0x03 with 16-clk strobe spacing.
    send_row(8'h05, 0, 1'b0, 3, -1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send_row(8'h03, NB, 1'b1, 15, -1);

    // Two identical rows back to back.
    send_row(8'h07, NB, 1'b1, 1, -1);
    send_row(8'h07, NB, 1'b1, 1, -1);

    // Long enable gap mid-row, random data and spacing.
    send_row(8'($urandom), NB, 1'b0, 0, 40);

    // Row byte truncation.
    send_row(8'hFF, NB, 1'b0, 0, -1);

    // Reset after 10 data bytes, then a fresh row.
    send_row(8'h0A, 10, 1'b0, 2, -1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs_zero("midrow_reset");
    reset = 1'b0;
    send_row(8'($urandom), NB, 1'b0, 0, -1);

    repeat (10) @(negedge clk);
    check("queue_drained", q.size(), 0);
    check("write_count", writes_seen, writes_exp);
    check("start_count", starts_seen, starts_exp);
    check("done_count", dones_seen, dones_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
